// File: rtl/qupls_agen_tlbq.sv
// Address-generator to TLB request queue: FIFO of generated addresses, one TLB request at a time,
// with cache-line-crossing accesses split into two sequential requests (original, then next line base).
module qupls_agen_tlbq #(
   parameter int DEPTH = 4,
   parameter int AWID  = 64,
   parameter int LINEW = 6,
   parameter int TAGW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            agen_v,
   input  logic [AWID-1:0] agen_adr,
   input  logic [2:0]      agen_sz,
   input  logic [TAGW-1:0] agen_id,
   input  logic            agen_st,
   output logic            agen_rdy,
   output logic            tlb_req,
   output logic [AWID-1:0] tlb_adr,
   output logic [TAGW-1:0] tlb_id,
   output logic            tlb_st,
   output logic            tlb_part,
   output logic            tlb_last,
   input  logic            tlb_ack,
   output logic            ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ST_FIRST, ST_SECOND} state_t;

   logic [AWID-1:0] q_adr   [DEPTH];
   logic [TAGW-1:0] q_id    [DEPTH];
   logic            q_st    [DEPTH];
   logic            q_split [DEPTH];

   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   state_t        state, state_nxt;

   logic [2:0]             sz_eff;
   logic [LINEW:0]         line_end;
   logic                   split_in;
   logic                   enq, pop;
   logic [AWID-1:0]        h_adr;
   logic                   h_split;
   logic [AWID-LINEW-1:0]  next_line;

   assign agen_rdy = (count < CW'(DEPTH));
   assign enq      = agen_v && agen_rdy && !flush;

   // Sizes above 16 bytes are clamped so the shift never exceeds the offset width.
   assign sz_eff   = (agen_sz > 3'd4) ? 3'd4 : agen_sz;
   assign line_end = {1'b0, agen_adr[LINEW-1:0]} + ((LINEW+1)'(1) << sz_eff);
   assign split_in = (line_end > ((LINEW+1)'(1) << LINEW));

   assign h_adr     = q_adr[head];
   assign h_split   = q_split[head];
   assign next_line = h_adr[AWID-1:LINEW] + (AWID-LINEW)'(1);
   assign tlb_id    = q_id[head];
   assign tlb_st    = q_st[head];

   always_comb begin
      state_nxt = state;
      tlb_req   = 1'b0;
      tlb_adr   = h_adr;
      tlb_part  = 1'b0;
      tlb_last  = !h_split;
      pop       = 1'b0;
      case (state)
         ST_FIRST: begin
            tlb_req = (count != '0);
            if (tlb_req && tlb_ack) begin
               if (h_split) state_nxt = ST_SECOND;
               else         pop       = 1'b1;
            end
         end
         ST_SECOND: begin
            tlb_req  = 1'b1;
            tlb_adr  = {next_line, {LINEW{1'b0}}};
            tlb_part = 1'b1;
            tlb_last = 1'b1;
            if (tlb_ack) begin
               pop       = 1'b1;
               state_nxt = ST_FIRST;
            end
         end
         default: state_nxt = ST_FIRST;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= ST_FIRST;
         ovf   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            q_adr[i]   <= '0;
            q_id[i]    <= '0;
            q_st[i]    <= 1'b0;
            q_split[i] <= 1'b0;
         end
      end else begin
         if (agen_v && !agen_rdy) ovf <= 1'b1;
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= ST_FIRST;
         end else begin
            state <= state_nxt;
            if (enq) begin
               q_adr[tail]   <= agen_adr;
               q_id[tail]    <= agen_id;
               q_st[tail]    <= agen_st;
               q_split[tail] <= split_in;
               tail          <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            case ({enq, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qupls_agen_tlbq.sv
// Bench for qupls_agen_tlbq: vector table of accesses with hand-computed split/next-line results,
// scoreboard queue of expected TLB requests, plus directed full/flush/reset sequences.
module tb_qupls_agen_tlbq;

   logic        clk = 1'b0;
   logic        rst, flush, agen_v, agen_st, tlb_ack;
   logic [63:0] agen_adr;
   logic [2:0]  agen_sz;
   logic [4:0]  agen_id;
   logic        agen_rdy, tlb_req, tlb_st, tlb_part, tlb_last, ovf;
   logic [63:0] tlb_adr;
   logic [4:0]  tlb_id;

   qupls_agen_tlbq #(.DEPTH(4), .AWID(64), .LINEW(6), .TAGW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .agen_v(agen_v), .agen_adr(agen_adr), .agen_sz(agen_sz), .agen_id(agen_id),
      .agen_st(agen_st), .agen_rdy(agen_rdy),
      .tlb_req(tlb_req), .tlb_adr(tlb_adr), .tlb_id(tlb_id), .tlb_st(tlb_st),
      .tlb_part(tlb_part), .tlb_last(tlb_last), .tlb_ack(tlb_ack), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] adr;
      logic [2:0]  sz;
      logic [4:0]  id;
      logic        st;
      logic        split;
      logic [63:0] adr2;
   } vec_t;

   typedef struct {
      logic [63:0] adr;
      logic [4:0]  id;
      logic        st;
      logic        part;
      logic        last;
   } req_t;

   vec_t tbl[12];
   req_t exp_q[$];
   int   cur;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, expv);
      end
   endtask

   task automatic drive(input int i);
      cur      = i;
      agen_v   = 1'b1;
      agen_adr = tbl[i].adr;
      agen_sz  = tbl[i].sz;
      agen_id  = tbl[i].id;
      agen_st  = tbl[i].st;
   endtask

   // Scoreboard bookkeeping for the upcoming edge, then advance one clock.
   task automatic cycle();
      req_t e;
      if (agen_v && agen_rdy && !flush) begin
         e.adr = tbl[cur].adr; e.id = tbl[cur].id; e.st = tbl[cur].st;
         e.part = 1'b0; e.last = !tbl[cur].split;
         exp_q.push_back(e);
         if (tbl[cur].split) begin
            e.adr = tbl[cur].adr2; e.part = 1'b1; e.last = 1'b1;
            exp_q.push_back(e);
         end
      end
      if (tlb_req && tlb_ack && !flush) begin
         if (exp_q.size() == 0) chk("sb_unexpected_req", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("sb_adr",  tlb_adr,  e.adr);
            chk("sb_id",   64'(tlb_id), 64'(e.id));
            chk("sb_st",   64'(tlb_st), 64'(e.st));
            chk("sb_part", 64'(tlb_part), 64'(e.part));
            chk("sb_last", 64'(tlb_last), 64'(e.last));
         end
      end
      if (flush) exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int g = 0;
      agen_v  = 1'b0;
      tlb_ack = 1'b1;
      while (tlb_req && g < 60) begin
         cycle();
         g++;
      end
      chk("drain_done", 64'(tlb_req), 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      tlb_ack = 1'b0;
   endtask

   initial begin
      //          adr                        sz    id     st    split adr2
      tbl[0]  = '{64'h0000_0000_0000_1000, 3'd3, 5'd2,  1'b0, 1'b0, 64'h0};
      tbl[1]  = '{64'h0000_0000_0000_103C, 3'd3, 5'd3,  1'b0, 1'b1, 64'h0000_0000_0000_1040};
      tbl[2]  = '{64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 5'd4,  1'b0, 1'b1, 64'h0};
      tbl[3]  = '{64'h0000_0000_0000_2038, 3'd3, 5'd5,  1'b1, 1'b0, 64'h0};
      tbl[4]  = '{64'h0000_0000_0000_2039, 3'd3, 5'd6,  1'b0, 1'b1, 64'h0000_0000_0000_2040};
      tbl[5]  = '{64'h0000_0000_0000_30FF, 3'd0, 5'd7,  1'b1, 1'b0, 64'h0};
      tbl[6]  = '{64'h0000_0000_0000_30FF, 3'd1, 5'd8,  1'b0, 1'b1, 64'h0000_0000_0000_3100};
      tbl[7]  = '{64'h0000_0000_0000_4031, 3'd7, 5'd9,  1'b1, 1'b1, 64'h0000_0000_0000_4040};
      tbl[8]  = '{64'h0000_0000_0000_4031, 3'd5, 5'd10, 1'b0, 1'b1, 64'h0000_0000_0000_4040};
      tbl[9]  = '{64'h0000_0000_0000_5004, 3'd2, 5'd11, 1'b0, 1'b0, 64'h0};
      tbl[10] = '{64'h0000_0000_0000_7FC0, 3'd4, 5'd12, 1'b1, 1'b0, 64'h0};
      tbl[11] = '{64'h0000_0000_0000_7FF1, 3'd4, 5'd13, 1'b1, 1'b1, 64'h0000_0000_0000_8000};

      rst = 1'b1; flush = 1'b0; agen_v = 1'b0; agen_adr = '0; agen_sz = '0;
      agen_id = '0; agen_st = 1'b0; tlb_ack = 1'b0; cur = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_agen_rdy", 64'(agen_rdy), 64'd1);
      chk("rst_tlb_req",  64'(tlb_req),  64'd0);
      chk("rst_tlb_adr",  tlb_adr,       64'd0);
      chk("rst_tlb_id",   64'(tlb_id),   64'd0);
      chk("rst_tlb_st",   64'(tlb_st),   64'd0);
      chk("rst_tlb_part", 64'(tlb_part), 64'd0);
      chk("rst_tlb_last", 64'(tlb_last), 64'd1);
      chk("rst_ovf",      64'(ovf),      64'd0);
      rst = 1'b0;
      cycle();

      // Single non-split access, no same-cycle bypass.
      drive(0);
      chk("single_nobypass", 64'(tlb_req), 64'd0);
      cycle();
      agen_v = 1'b0;
      chk("single_req",  64'(tlb_req),  64'd1);
      chk("single_adr",  tlb_adr,       64'h1000);
      chk("single_last", 64'(tlb_last), 64'd1);
      tlb_ack = 1'b1;
      cycle();
      tlb_ack = 1'b0;
      chk("single_popped", 64'(tlb_req), 64'd0);

      // Line-crossing split.
      drive(1);
      cycle();
      agen_v = 1'b0;
      chk("split_p0_part", 64'(tlb_part), 64'd0);
      chk("split_p0_last", 64'(tlb_last), 64'd0);
      tlb_ack = 1'b1;
      cycle();
      chk("split_p1_adr",  tlb_adr,       64'h1040);
      chk("split_p1_part", 64'(tlb_part), 64'd1);
      chk("split_p1_id",   64'(tlb_id),   64'd3);
      cycle();
      tlb_ack = 1'b0;
      chk("split_done", 64'(tlb_req), 64'd0);

      // Top-of-address-space wrap of the second part.
      drive(2);
      cycle();
      agen_v  = 1'b0;
      tlb_ack = 1'b1;
      cycle();
      chk("wrap_p1_adr",  tlb_adr,       64'd0);
      chk("wrap_p1_part", 64'(tlb_part), 64'd1);
      cycle();
      tlb_ack = 1'b0;

      // Full queue, overflow, FIFO order on drain.
      for (int i = 3; i <= 6; i++) begin
         drive(i);
         cycle();
      end
      agen_v = 1'b0;
      chk("full_rdy_low", 64'(agen_rdy), 64'd0);
      chk("full_no_ovf",  64'(ovf),      64'd0);
      drive(7);
      cycle();
      agen_v = 1'b0;
      chk("full_ovf_set", 64'(ovf), 64'd1);
      tlb_ack = 1'b1;
      chk("full_rdy_during_pop", 64'(agen_rdy), 64'd0);
      cycle();
      chk("full_rdy_after_pop", 64'(agen_rdy), 64'd1);
      drain();

      // Flush during the second part of a split, with a same-cycle enqueue.
      drive(4);
      cycle();
      agen_v  = 1'b0;
      tlb_ack = 1'b1;
      cycle();
      chk("flush_in_second", 64'(tlb_part), 64'd1);
      flush = 1'b1;
      drive(0);
      cycle();
      flush = 1'b0; agen_v = 1'b0; tlb_ack = 1'b0;
      chk("flush_req",      64'(tlb_req),  64'd0);
      chk("flush_rdy",      64'(agen_rdy), 64'd1);
      chk("flush_ovf_kept", 64'(ovf),      64'd1);
      cycle();
      chk("flush_dropped", 64'(tlb_req), 64'd0);
      drive(9);
      cycle();
      agen_v = 1'b0;
      chk("flush_state_first", 64'(tlb_part), 64'd0);
      chk("flush_new_adr",     tlb_adr,       64'h5004);
      drain();

      // Simultaneous enqueue and pop at count 2 keeps count at 2.
      drive(0);
      cycle();
      drive(9);
      cycle();
      drive(10);
      tlb_ack = 1'b1;
      cycle();
      tlb_ack = 1'b0;
      drive(5);
      cycle();
      agen_v = 1'b0;
      chk("cnt2_rdy_at3", 64'(agen_rdy), 64'd1);
      drive(3);
      cycle();
      agen_v = 1'b0;
      chk("cnt2_rdy_at4", 64'(agen_rdy), 64'd0);
      drain();

      // Streaming all vectors with continuous ack, wrapping the pointers several times.
      tlb_ack = 1'b1;
      for (int i = 0; i < 12; i++) begin
         int g = 0;
         agen_v = 1'b0;
         while (!agen_rdy && g < 20) begin
            cycle();
            g++;
         end
         chk("stream_rdy", 64'(agen_rdy), 64'd1);
         drive(i);
         cycle();
      end
      drain();

      // Reset in the middle of a split discards the second part.
      drive(1);
      cycle();
      agen_v  = 1'b0;
      tlb_ack = 1'b1;
      cycle();
      tlb_ack = 1'b0;
      chk("rst_mid_part1", 64'(tlb_part), 64'd1);
      rst = 1'b1;
      #2;
      chk("rst_mid_req", 64'(tlb_req),  64'd0);
      chk("rst_mid_ovf", 64'(ovf),      64'd0);
      chk("rst_mid_rdy", 64'(agen_rdy), 64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle();
      chk("rst_mid_idle", 64'(tlb_req), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qupls_agen_tlbq.md
# qupls_agen_tlbq

Request queue and line splitter between the load/store address generator and the TLB. Accepts generated virtual addresses with access size and ROB tag, buffers them in a small FIFO, and presents them one at a time to the TLB. Accesses that cross a cache-line boundary are split into two sequential TLB requests: the original address, then the base of the next line.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- AWID, 64: virtual address width.
- LINEW, 6: log2 of cache-line bytes (64-byte lines).
- TAGW, 5: ROB tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  branch-miss flush; discards all queued and in-flight requests.
- agen_v  in  1  address valid from the address generator.
- agen_adr  in  AWID  virtual address.
- agen_sz  in  3  log2 access bytes; 0..4 (1..16 bytes); 5..7 are treated as 4.
- agen_id  in  TAGW  ROB tag.
- agen_st  in  1  store (1) / load (0).
- agen_rdy  out  1  queue can accept; combinational, count < DEPTH.
- tlb_req  out  1  request valid to TLB.
- tlb_adr  out  AWID  request address.
- tlb_id  out  TAGW  ROB tag of request.
- tlb_st  out  1  store flag of request.
- tlb_part  out  1  0 = first or only part, 1 = second part of a split.
- tlb_last  out  1  final request for this access.
- tlb_ack  in  1  TLB accepts current request this cycle.
- ovf  out  1  sticky: agen_v seen while agen_rdy low.

## Operation
- Enqueue when agen_v && agen_rdy && !flush: write {adr, sz, id, st, split} at tail; tail++ and count++ (modulo DEPTH).
- split = (agen_adr[LINEW-1:0] + (1 << sz)) > 2**LINEW, computed at enqueue using LINEW+1-bit arithmetic.
- Output FSM, two states:
  - FIRST: tlb_req = (count != 0); tlb_adr = head.adr; tlb_part = 0; tlb_last = !head.split. On tlb_ack: if head.split, go to SECOND; otherwise pop the head.
  - SECOND: tlb_req = 1; tlb_adr = {head.adr[AWID-1:LINEW] + 1, LINEW'b0}, wrapping modulo 2**AWID (all-ones line goes to 0); tlb_part = 1; tlb_last = 1. On tlb_ack: pop the head and go to FIRST.
- Pop: head++, count--. Enqueue and pop in the same cycle leave count unchanged.
- tlb_id and tlb_st always come from the head entry.
- tlb_ack while tlb_req is low is ignored.
- flush (synchronous): head = tail = count = 0, state = FIRST. flush overrides any same-cycle enqueue and ack.
- ovf sets on agen_v && !agen_rdy. It clears only on rst; flush does not clear it.

## Timing
- Reset values: agen_rdy = 1; tlb_req = 0; tlb_adr = 0; tlb_id = 0; tlb_st = 0; tlb_part = 0; tlb_last = 1; ovf = 0. FSM = FIRST, count = 0.
- Latency: an entry enqueued at edge N appears on tlb_req after edge N when the queue was empty. There is no same-cycle bypass.
- All tlb_* outputs are driven from flops (head entry plus FSM state) and are stable while tlb_req && !tlb_ack.
- Full queue: agen_rdy is low even if tlb_ack pops in the same cycle. Space becomes visible the cycle after the pop.
- Throughput: one TLB request per cycle with continuous ack. A split access occupies two ack cycles.
- rst asserted mid-split discards the pending second part.

## Test plan
- Single non-split: adr=0x1000, sz=3, id=2, ld. Response: tlb_req high 1 cycle later with adr 0x1000, part 0, last 1; ack pops the entry and tlb_req drops.
- Line-crossing split: adr=0x103C, sz=3. Response: first request 0x103C (part 0, last 0); after ack, 0x1040 (part 1, last 1) with the same id; second ack pops.
- Top-of-space wrap: adr=0xFFFF_FFFF_FFFF_FFF8, sz=4. Response: second request adr = 0.
- Full/backpressure: hold tlb_ack low and enqueue 4 entries. Response: agen_rdy goes low after the 4th. A 5th agen_v sets ovf, and that entry is not stored. Acks then return the 4 entries in FIFO order.
- Flush mid-split: ack the first part of a split, then assert flush together with agen_v. Response: next cycle tlb_req = 0, count = 0, the new entry is dropped, and agen_rdy = 1.
- Simultaneous enqueue and pop at count=2: count stays 2, and order is preserved across head/tail wrap (run more than 8 accesses).
